// File: rtl/core_pkg.sv
// Shared core types for the load/store reservation station.
// Field widths and the RS entry record used by rs_du and its wakeup sub-module.
package core_pkg;

    localparam int unsigned PHY_W  = 6;
    localparam int unsigned CW_W   = 4;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned DATA_W = 32;

    typedef logic [PHY_W-1:0]  phy_t;
    typedef logic [CW_W-1:0]   cw_t;
    typedef logic [OP_W-1:0]   op_t;
    typedef logic [DATA_W-1:0] data_t;

    // One reservation-station slot.
    typedef struct packed {
        logic  valid;
        op_t   op;
        data_t imm;
        phy_t  rdst;
        cw_t   cw;
        phy_t  src1_tag;
        logic  src1_rdy;
        data_t src1;
        phy_t  src2_tag;
        logic  src2_rdy;
        data_t src2;
    } rs_entry_t;

endpackage

// File: rtl/rs_du_if.sv
// Bus bundle for rs_du: dispatch payload, CDB broadcast, issue port to the
// data unit and the RS_full / Unit_busy flow-control pair.
// slave  : the reservation station side.
// master : the dispatcher / CDB / data-unit environment side.
interface rs_du_if;
    import core_pkg::*;

    // Dispatch
    logic  Dispatch_en;
    op_t   Dispatch_Operation;
    data_t Dispatch_imm;
    phy_t  Dispatch_PhyRdst;
    cw_t   Dispatch_Commit_window;
    phy_t  Dispatch_PhySrc1;
    phy_t  Dispatch_PhySrc2;
    logic  Dispatch_Src1_ready;
    logic  Dispatch_Src2_ready;
    data_t Dispatch_Src1;
    data_t Dispatch_Src2;

    // Common data bus
    logic  CDB_valid;
    logic  CDB_Write_Phy;
    phy_t  CDB_PhyRdst;
    data_t CDB_data;

    // Flow control
    logic  RS_full;
    logic  Unit_busy;

    // Issue
    op_t   EX_Operation;
    data_t EX_imm;
    data_t EX_Src1;
    data_t EX_Src2;
    phy_t  EX_PhyRdst;
    cw_t   EX_Commit_window;
    logic  EX_en;

    modport slave (
        input  Dispatch_en, Dispatch_Operation, Dispatch_imm, Dispatch_PhyRdst,
               Dispatch_Commit_window, Dispatch_PhySrc1, Dispatch_PhySrc2,
               Dispatch_Src1_ready, Dispatch_Src2_ready, Dispatch_Src1, Dispatch_Src2,
               CDB_valid, CDB_Write_Phy, CDB_PhyRdst, CDB_data, Unit_busy,
        output RS_full, EX_Operation, EX_imm, EX_Src1, EX_Src2, EX_PhyRdst,
               EX_Commit_window, EX_en
    );

    modport master (
        output Dispatch_en, Dispatch_Operation, Dispatch_imm, Dispatch_PhyRdst,
               Dispatch_Commit_window, Dispatch_PhySrc1, Dispatch_PhySrc2,
               Dispatch_Src1_ready, Dispatch_Src2_ready, Dispatch_Src1, Dispatch_Src2,
               CDB_valid, CDB_Write_Phy, CDB_PhyRdst, CDB_data, Unit_busy,
        input  RS_full, EX_Operation, EX_imm, EX_Src1, EX_Src2, EX_PhyRdst,
               EX_Commit_window, EX_en
    );

endinterface

// File: rtl/rs_du_wakeup.sv
// Per-operand wakeup: compares an operand tag against the CDB broadcast and
// produces the operand's next ready flag and value.
// Ports: en_i (operand belongs to a live entry), tag_i/rdy_i/data_i (current
// operand), cdb_en_i/cdb_tag_i/cdb_data_i (qualified broadcast),
// rdy_c_o/data_c_o (combinational next ready/value).
module rs_du_wakeup
    import core_pkg::*;
(
    input  logic  en_i,
    input  phy_t  tag_i,
    input  logic  rdy_i,
    input  data_t data_i,
    input  logic  cdb_en_i,
    input  phy_t  cdb_tag_i,
    input  data_t cdb_data_i,
    output logic  rdy_c_o,
    output data_t data_c_o
);

    logic hit_c;

    // Only a still-waiting operand may capture the broadcast.
    assign hit_c    = en_i & cdb_en_i & ~rdy_i & (tag_i == cdb_tag_i);
    assign rdy_c_o  = rdy_i | hit_c;
    assign data_c_o = hit_c ? cdb_data_i : data_i;

endmodule

// File: rtl/rs_du.sv
// In-order load/store reservation station: a circular FIFO of DEPTH entries
// that wakes operands from the CDB and issues only from the head.
// Ports: clk, rst (sync, active-high), flush (mispredict discard),
// rs (rs_du_if.slave: dispatch, CDB, Unit_busy in; RS_full, EX_* out).
module rs_du
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    rs_du_if.slave     rs
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rs_entry_t        ent_q [DEPTH];
    rs_entry_t        ent_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_q, hold_d;

    rs_entry_t        head_c;
    logic             full_c;
    logic             cdb_en_c;
    logic             do_disp_c;
    logic             ex_en_c;

    logic [DEPTH-1:0] wr_c;
    logic [DEPTH-1:0] live_c;
    logic [DEPTH-1:0] w1_rdy_c;
    logic [DEPTH-1:0] w2_rdy_c;
    data_t            w1_data_c [DEPTH];
    data_t            w2_data_c [DEPTH];

    // Flow control and issue qualification, all from registered state.
    assign head_c    = ent_q[head_q];
    assign full_c    = (cnt_q == CNT_W'(DEPTH));
    assign cdb_en_c  = rs.CDB_valid & rs.CDB_Write_Phy;
    assign do_disp_c = rs.Dispatch_en & ~full_c & ~flush;
    // hold_q blocks back-to-back issue so the data unit's busy flag can catch up.
    assign ex_en_c   = (cnt_q != '0) & head_c.valid & head_c.src1_rdy & head_c.src2_rdy
                     & ~rs.Unit_busy & ~hold_q & ~flush;

    // Per-entry operand wakeup; a dispatching entry is fed its incoming
    // operands so a same-cycle broadcast is captured on the way in.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        phy_t  t1_c, t2_c;
        logic  r1_c, r2_c;
        data_t d1_c, d2_c;

        assign wr_c[i]   = do_disp_c && (tail_q == PTR_W'(i));
        assign live_c[i] = wr_c[i] | ent_q[i].valid;

        assign t1_c = wr_c[i] ? rs.Dispatch_PhySrc1    : ent_q[i].src1_tag;
        assign r1_c = wr_c[i] ? rs.Dispatch_Src1_ready : ent_q[i].src1_rdy;
        assign d1_c = wr_c[i] ? rs.Dispatch_Src1       : ent_q[i].src1;
        assign t2_c = wr_c[i] ? rs.Dispatch_PhySrc2    : ent_q[i].src2_tag;
        assign r2_c = wr_c[i] ? rs.Dispatch_Src2_ready : ent_q[i].src2_rdy;
        assign d2_c = wr_c[i] ? rs.Dispatch_Src2       : ent_q[i].src2;

        rs_du_wakeup u_wk1 (
            .en_i       (live_c[i]),
            .tag_i      (t1_c),
            .rdy_i      (r1_c),
            .data_i     (d1_c),
            .cdb_en_i   (cdb_en_c),
            .cdb_tag_i  (rs.CDB_PhyRdst),
            .cdb_data_i (rs.CDB_data),
            .rdy_c_o    (w1_rdy_c[i]),
            .data_c_o   (w1_data_c[i])
        );

        rs_du_wakeup u_wk2 (
            .en_i       (live_c[i]),
            .tag_i      (t2_c),
            .rdy_i      (r2_c),
            .data_i     (d2_c),
            .cdb_en_i   (cdb_en_c),
            .cdb_tag_i  (rs.CDB_PhyRdst),
            .cdb_data_i (rs.CDB_data),
            .rdy_c_o    (w2_rdy_c[i]),
            .data_c_o   (w2_data_c[i])
        );
    end

    // Next-state: dispatch write, wakeup, issue retire, then flush override.
    always_comb begin
        ent_d  = ent_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        hold_d = ex_en_c;

        for (int i = 0; i < DEPTH; i++) begin
            if (wr_c[i]) begin
                ent_d[i].valid    = 1'b1;
                ent_d[i].op       = rs.Dispatch_Operation;
                ent_d[i].imm      = rs.Dispatch_imm;
                ent_d[i].rdst     = rs.Dispatch_PhyRdst;
                ent_d[i].cw       = rs.Dispatch_Commit_window;
                ent_d[i].src1_tag = rs.Dispatch_PhySrc1;
                ent_d[i].src2_tag = rs.Dispatch_PhySrc2;
            end
            if (live_c[i]) begin
                ent_d[i].src1_rdy = w1_rdy_c[i];
                ent_d[i].src1     = w1_data_c[i];
                ent_d[i].src2_rdy = w2_rdy_c[i];
                ent_d[i].src2     = w2_data_c[i];
            end
        end

        // Pointers wrap naturally since DEPTH is a power of two.
        if (do_disp_c) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (ex_en_c) begin
            ent_d[head_q].valid = 1'b0;
            head_d              = head_q + PTR_W'(1);
        end

        case ({do_disp_c, ex_en_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
            hold_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            hold_q <= 1'b0;
        end else begin
            ent_q  <= ent_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
        end
    end

    // Issue payload straight from the head slot.
    assign rs.RS_full          = full_c;
    assign rs.EX_en            = ex_en_c;
    assign rs.EX_Operation     = head_c.op;
    assign rs.EX_imm           = head_c.imm;
    assign rs.EX_Src1          = head_c.src1;
    assign rs.EX_Src2          = head_c.src2;
    assign rs.EX_PhyRdst       = head_c.rdst;
    assign rs.EX_Commit_window = head_c.cw;

endmodule

// File: tb/tb_rs_du.sv
// Directed bench for rs_du: expected issue records are queued at dispatch and
// popped whenever EX_en is seen; cycle-specific checks cover flow control.
module tb_rs_du;
    import core_pkg::*;

    typedef struct packed {
        op_t   op;
        data_t imm;
        data_t s1;
        data_t s2;
        phy_t  rd;
        cw_t   cw;
    } iss_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  flush;
    int    checks = 0;
    int    errors = 0;
    iss_t  exp_q[$];
    iss_t  mon_obs;
    iss_t  mon_exp;

    rs_du_if u_if ();

    rs_du #(.DEPTH(4)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .rs    (u_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        u_if.Dispatch_en   = 1'b0;
        u_if.CDB_valid     = 1'b0;
        u_if.CDB_Write_Phy = 1'b0;
        flush              = 1'b0;
    endtask

    task automatic disp(input op_t op, input data_t imm, input cw_t cw,
                        input phy_t t1, input logic r1, input data_t s1,
                        input phy_t t2, input logic r2, input data_t s2,
                        input data_t e1, input data_t e2, input bit push);
        phy_t rd;
        rd = {2'b01, cw};
        u_if.Dispatch_en            = 1'b1;
        u_if.Dispatch_Operation     = op;
        u_if.Dispatch_imm           = imm;
        u_if.Dispatch_PhyRdst       = rd;
        u_if.Dispatch_Commit_window = cw;
        u_if.Dispatch_PhySrc1       = t1;
        u_if.Dispatch_Src1_ready    = r1;
        u_if.Dispatch_Src1          = s1;
        u_if.Dispatch_PhySrc2       = t2;
        u_if.Dispatch_Src2_ready    = r2;
        u_if.Dispatch_Src2          = s2;
        if (push) exp_q.push_back('{op, imm, e1, e2, rd, cw});
    endtask

    task automatic cdb(input logic wr, input phy_t tag, input data_t d);
        u_if.CDB_valid     = 1'b1;
        u_if.CDB_Write_Phy = wr;
        u_if.CDB_PhyRdst   = tag;
        u_if.CDB_data      = d;
    endtask

    // Scoreboard: every issue must match the oldest outstanding dispatch.
    always @(negedge clk) begin
        if (!rst && u_if.EX_en === 1'b1) begin
            mon_obs = '{u_if.EX_Operation, u_if.EX_imm, u_if.EX_Src1, u_if.EX_Src2,
                        u_if.EX_PhyRdst, u_if.EX_Commit_window};
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_issue observed=%h expected=no_issue", mon_obs);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                checks++;
                assert (mon_obs === mon_exp) else begin
                    errors++;
                    $error("FAIL sb_issue observed=%h expected=%h", mon_obs, mon_exp);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        u_if.Unit_busy = 1'b0;
        u_if.Dispatch_en = 1'b0;
        u_if.Dispatch_Operation = '0;
        u_if.Dispatch_imm = '0;
        u_if.Dispatch_PhyRdst = '0;
        u_if.Dispatch_Commit_window = '0;
        u_if.Dispatch_PhySrc1 = '0;
        u_if.Dispatch_PhySrc2 = '0;
        u_if.Dispatch_Src1_ready = 1'b0;
        u_if.Dispatch_Src2_ready = 1'b0;
        u_if.Dispatch_Src1 = '0;
        u_if.Dispatch_Src2 = '0;
        u_if.CDB_valid = 1'b0;
        u_if.CDB_Write_Phy = 1'b0;
        u_if.CDB_PhyRdst = '0;
        u_if.CDB_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_full", 32'(u_if.RS_full), 32'd0);
        chk("rst_ex_en", 32'(u_if.EX_en), 32'd0);
        chk("rst_op", 32'(u_if.EX_Operation), 32'd0);
        chk("rst_imm", u_if.EX_imm, 32'd0);
        chk("rst_src1", u_if.EX_Src1, 32'd0);
        chk("rst_src2", u_if.EX_Src2, 32'd0);
        chk("rst_rdst", 32'(u_if.EX_PhyRdst), 32'd0);
        chk("rst_cw", 32'(u_if.EX_Commit_window), 32'd0);
        next_cyc();

        // Basic issue, then one-cycle hold with a second entry waiting
        disp(6'h23, 32'd4, 4'd1, 6'd1, 1'b1, 32'h100, 6'd2, 1'b1, 32'h7, 32'h100, 32'h7, 1'b1);
        @(negedge clk); chk("t1_empty_en", 32'(u_if.EX_en), 32'd0);
        next_cyc();
        disp(6'h2b, 32'd8, 4'd2, 6'd3, 1'b1, 32'h200, 6'd4, 1'b1, 32'h300, 32'h200, 32'h300, 1'b1);
        @(negedge clk);
        chk("t1_issue_en", 32'(u_if.EX_en), 32'd1);
        chk("t1_src1", u_if.EX_Src1, 32'h100);
        chk("t1_imm", u_if.EX_imm, 32'd4);
        next_cyc();
        @(negedge clk); chk("t1_hold_en", 32'(u_if.EX_en), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("t1_second_en", 32'(u_if.EX_en), 32'd1);
        chk("t1_second_src1", u_if.EX_Src1, 32'h200);
        next_cyc();
        @(negedge clk); chk("t1_drained_en", 32'(u_if.EX_en), 32'd0);
        next_cyc();

        // Src2 woken by a later CDB broadcast
        disp(6'h23, 32'h10, 4'd3, 6'd1, 1'b1, 32'h11, 6'd9, 1'b0, 32'h0, 32'h11, 32'hDEADBEEF, 1'b1);
        @(negedge clk); chk("t2_disp_en", 32'(u_if.EX_en), 32'd0);
        next_cyc();
        @(negedge clk); chk("t2_wait_en", 32'(u_if.EX_en), 32'd0);
        next_cyc();
        cdb(1'b1, 6'd9, 32'hDEADBEEF);
        @(negedge clk); chk("t2_cdb_cycle_en", 32'(u_if.EX_en), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("t2_issue_en", 32'(u_if.EX_en), 32'd1);
        chk("t2_src2", u_if.EX_Src2, 32'hDEADBEEF);
        next_cyc();
        next_cyc();

        // CDB bypass into the dispatching entry
        disp(6'h2b, 32'h20, 4'd4, 6'd5, 1'b0, 32'h0, 6'd6, 1'b1, 32'h66, 32'h55, 32'h66, 1'b1);
        cdb(1'b1, 6'd5, 32'h55);
        @(negedge clk); chk("t3_disp_en", 32'(u_if.EX_en), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("t3_issue_en", 32'(u_if.EX_en), 32'd1);
        chk("t3_src1", u_if.EX_Src1, 32'h55);
        next_cyc();
        next_cyc();

        // Fill while busy, drop dispatch when full, drain in order
        u_if.Unit_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            disp(6'h23, 32'(k), cw_t'(k), 6'd1, 1'b1, 32'h1000 + 32'(k), 6'd2, 1'b1,
                 32'h2000 + 32'(k), 32'h1000 + 32'(k), 32'h2000 + 32'(k), 1'b1);
            @(negedge clk);
            chk("t4_fill_full", 32'(u_if.RS_full), 32'd0);
            chk("t4_fill_en", 32'(u_if.EX_en), 32'd0);
            next_cyc();
        end
        disp(6'h23, 32'd99, 4'd7, 6'd1, 1'b1, 32'h77, 6'd2, 1'b1, 32'h77, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("t4_full", 32'(u_if.RS_full), 32'd1);
        chk("t4_busy_en", 32'(u_if.EX_en), 32'd0);
        next_cyc();
        u_if.Unit_busy = 1'b0;
        disp(6'h23, 32'd98, 4'd8, 6'd1, 1'b1, 32'h88, 6'd2, 1'b1, 32'h88, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("t4_full_on_issue", 32'(u_if.RS_full), 32'd1);
        chk("t4_release_en", 32'(u_if.EX_en), 32'd1);
        chk("t4_first_cw", 32'(u_if.EX_Commit_window), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("t4_not_full", 32'(u_if.RS_full), 32'd0);
        chk("t4_hold_en", 32'(u_if.EX_en), 32'd0);
        next_cyc();
        repeat (6) next_cyc();
        chk("t4_sb_drained", 32'(exp_q.size()), 32'd0);

        // In-order: ready second entry waits behind a blocked head
        disp(6'h23, 32'h30, 4'd9, 6'd12, 1'b0, 32'h0, 6'd13, 1'b1, 32'h22, 32'hC0FFEE, 32'h22, 1'b1);
        @(negedge clk); chk("t5_disp_en", 32'(u_if.EX_en), 32'd0);
        next_cyc();
        disp(6'h2b, 32'h31, 4'd10, 6'd1, 1'b1, 32'hA1, 6'd2, 1'b1, 32'hA2, 32'hA1, 32'hA2, 1'b1);
        @(negedge clk); chk("t5_blocked_en0", 32'(u_if.EX_en), 32'd0);
        next_cyc();
        cdb(1'b0, 6'd12, 32'hBAD);
        @(negedge clk); chk("t5_blocked_en1", 32'(u_if.EX_en), 32'd0);
        next_cyc();
        @(negedge clk); chk("t5_no_wr_phy_en", 32'(u_if.EX_en), 32'd0);
        next_cyc();
        cdb(1'b1, 6'd12, 32'hC0FFEE);
        @(negedge clk); chk("t5_wake_cycle_en", 32'(u_if.EX_en), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("t5_head_en", 32'(u_if.EX_en), 32'd1);
        chk("t5_head_cw", 32'(u_if.EX_Commit_window), 32'd9);
        next_cyc();
        @(negedge clk); chk("t5_hold_en", 32'(u_if.EX_en), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("t5_next_en", 32'(u_if.EX_en), 32'd1);
        chk("t5_next_cw", 32'(u_if.EX_Commit_window), 32'd10);
        next_cyc();
        next_cyc();

        // Flush with three entries; dispatch in flush cycle is dropped
        u_if.Unit_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            disp(6'h23, 32'd0, cw_t'(11 + k), 6'd1, 1'b1, 32'h5, 6'd2, 1'b1, 32'h6, 32'h0, 32'h0, 1'b0);
            next_cyc();
        end
        u_if.Unit_busy = 1'b0;
        flush = 1'b1;
        disp(6'h23, 32'd0, 4'd14, 6'd1, 1'b1, 32'h5, 6'd2, 1'b1, 32'h6, 32'h0, 32'h0, 1'b0);
        @(negedge clk); chk("t6_flush_cycle_en", 32'(u_if.EX_en), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("t6_post_full", 32'(u_if.RS_full), 32'd0);
        chk("t6_post_en", 32'(u_if.EX_en), 32'd0);
        next_cyc();

        // Pointer wrap: dispatch alongside issue, count stays at one
        disp(6'h23, 32'd0, 4'd0, 6'd1, 1'b1, 32'hF00, 6'd2, 1'b1, 32'hF80, 32'hF00, 32'hF80, 1'b1);
        @(negedge clk); chk("t6_wrap_first_en", 32'(u_if.EX_en), 32'd0);
        next_cyc();
        for (int k = 1; k <= 6; k++) begin
            disp(6'h2b, 32'(k), cw_t'(k), 6'd1, 1'b1, 32'hF00 + 32'(k), 6'd2, 1'b1,
                 32'hF80 + 32'(k), 32'hF00 + 32'(k), 32'hF80 + 32'(k), 1'b1);
            @(negedge clk);
            chk("t6_wrap_issue_en", 32'(u_if.EX_en), 32'd1);
            chk("t6_wrap_issue_cw", 32'(u_if.EX_Commit_window), 32'(k - 1));
            next_cyc();
            @(negedge clk); chk("t6_wrap_hold_en", 32'(u_if.EX_en), 32'd0);
            next_cyc();
        end
        @(negedge clk);
        chk("t6_wrap_last_en", 32'(u_if.EX_en), 32'd1);
        chk("t6_wrap_last_cw", 32'(u_if.EX_Commit_window), 32'd6);
        next_cyc();
        repeat (2) next_cyc();
        chk("final_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
